// File: rtl/zest_spi_arb_pkg.sv
// Shared types, widths and helpers for the Zest configuration SPI arbiter.
package zest_spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam int unsigned TCW = 16;

  // Round-robin successor of a grant index, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/zest_spi_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer.
module zest_spi_arb_rr_pick #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDW   = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  output logic             o_vld,
  output logic [IDW-1:0]   o_idx
);

  always_comb begin
    int unsigned j;
    o_vld = 1'b0;
    o_idx = '0;
    j     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = (32'(i_ptr) + k) % N_REQ;
      if (!o_vld && i_req[j[IDW-1:0]]) begin
        o_vld = 1'b1;
        o_idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/zest_spi_arb.sv
// Round-robin arbiter/sequencer sharing one Zest config SPI master between N requesters.
module zest_spi_arb
  import zest_spi_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned DW      = 24,
  parameter int unsigned CSW     = 3,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic                       lb_clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*CSW-1:0]       req_sel,
  input  logic [N_REQ*DW-1:0]        req_data,
  input  logic [N_REQ-1:0]           req_rd,
  output logic [N_REQ-1:0]           ack,
  output logic [N_REQ-1:0]           err,
  output logic [DW-1:0]              rdata,
  output logic                       spi_start,
  output logic [CSW-1:0]             spi_sel,
  output logic [DW-1:0]              spi_data,
  output logic                       spi_rd,
  input  logic                       spi_busy,
  input  logic                       spi_done,
  input  logic [DW-1:0]              spi_rdata,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic [TCW-1:0]             timeout_cnt
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned WCW = $clog2(TIMEOUT + 1);

  state_t           r_state, w_state_nxt;
  logic [IDW-1:0]   r_ptr, w_ptr_nxt;
  logic [WCW-1:0]   r_wcnt, w_wcnt_nxt, w_wcnt_inc;
  logic             r_to, w_to_nxt;
  logic [DW-1:0]    r_data, w_data_nxt;

  logic [N_REQ-1:0] r_ack, w_ack_nxt;
  logic [N_REQ-1:0] r_err, w_err_nxt;
  logic [DW-1:0]    r_rdata, w_rdata_nxt;
  logic             r_start, w_start_nxt;
  logic [CSW-1:0]   r_sel, w_sel_nxt;
  logic [DW-1:0]    r_spi_data, w_spi_data_nxt;
  logic             r_rd, w_rd_nxt;
  logic [IDW-1:0]   r_grant, w_grant_nxt;
  logic             r_busy, w_busy_nxt;
  logic [TCW-1:0]   r_tcnt, w_tcnt_nxt;

  logic             w_pick_vld;
  logic [IDW-1:0]   w_pick_idx;

  zest_spi_arb_rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_vld (w_pick_vld),
    .o_idx (w_pick_idx)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_wcnt_nxt     = r_wcnt;
    w_wcnt_inc     = r_wcnt + WCW'(1);
    w_to_nxt       = r_to;
    w_data_nxt     = r_data;
    w_ack_nxt      = '0;
    w_err_nxt      = '0;
    w_rdata_nxt    = r_rdata;
    w_start_nxt    = 1'b0;
    w_sel_nxt      = r_sel;
    w_spi_data_nxt = '0;
    w_rd_nxt       = r_rd;
    w_grant_nxt    = r_grant;
    w_tcnt_nxt     = r_tcnt;

    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_grant_nxt = w_pick_idx;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_pick_idx == IDW'(i)) begin
              w_sel_nxt  = req_sel[i*CSW +: CSW];
              w_data_nxt = req_data[i*DW +: DW];
              w_rd_nxt   = req_rd[i];
            end
          end
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!spi_busy) begin
          w_start_nxt    = 1'b1;
          w_spi_data_nxt = r_data;
          w_wcnt_nxt     = '0;
          w_state_nxt    = WAIT;
        end
      end
      WAIT: begin
        w_wcnt_nxt = w_wcnt_inc;
        // Completion takes priority over a coincident timeout.
        if (spi_done) begin
          w_rdata_nxt = spi_rdata;
          w_to_nxt    = 1'b0;
          w_state_nxt = ACK;
        end else if (w_wcnt_inc == WCW'(TIMEOUT)) begin
          w_rdata_nxt = '0;
          w_to_nxt    = 1'b1;
          if (r_tcnt != '1) w_tcnt_nxt = r_tcnt + TCW'(1);
          w_state_nxt = ACK;
        end
      end
      ACK: begin
        w_ack_nxt   = N_REQ'(1) << r_grant;
        w_err_nxt   = r_to ? (N_REQ'(1) << r_grant) : '0;
        w_ptr_nxt   = IDW'(rr_next(32'(r_grant), N_REQ));
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State register.
  always_ff @(posedge lb_clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Datapath and output registers.
  always_ff @(posedge lb_clk) begin
    if (reset) begin
      r_ptr      <= '0;
      r_wcnt     <= '0;
      r_to       <= 1'b0;
      r_data     <= '0;
      r_ack      <= '0;
      r_err      <= '0;
      r_rdata    <= '0;
      r_start    <= 1'b0;
      r_sel      <= '0;
      r_spi_data <= '0;
      r_rd       <= 1'b0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_tcnt     <= '0;
    end else begin
      r_ptr      <= w_ptr_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_to       <= w_to_nxt;
      r_data     <= w_data_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_rdata    <= w_rdata_nxt;
      r_start    <= w_start_nxt;
      r_sel      <= w_sel_nxt;
      r_spi_data <= w_spi_data_nxt;
      r_rd       <= w_rd_nxt;
      r_grant    <= w_grant_nxt;
      r_busy     <= w_busy_nxt;
      r_tcnt     <= w_tcnt_nxt;
    end
  end

  assign ack         = r_ack;
  assign err         = r_err;
  assign rdata       = r_rdata;
  assign spi_start   = r_start;
  assign spi_sel     = r_sel;
  assign spi_data    = r_spi_data;
  assign spi_rd      = r_rd;
  assign grant_id    = r_grant;
  assign busy        = r_busy;
  assign timeout_cnt = r_tcnt;

endmodule

// File: tb/tb_zest_spi_arb.sv
// Directed self-checking bench for zest_spi_arb (N_REQ=3, TIMEOUT=15).
module tb_zest_spi_arb;

  localparam int unsigned N_REQ   = 3;
  localparam int unsigned DW      = 24;
  localparam int unsigned CSW     = 3;
  localparam int unsigned TIMEOUT = 15;

  logic                 lb_clk = 1'b0;
  logic                 reset;
  logic [N_REQ-1:0]     req;
  logic [N_REQ*CSW-1:0] req_sel;
  logic [N_REQ*DW-1:0]  req_data;
  logic [N_REQ-1:0]     req_rd;
  logic [N_REQ-1:0]     ack;
  logic [N_REQ-1:0]     err;
  logic [DW-1:0]        rdata;
  logic                 spi_start;
  logic [CSW-1:0]       spi_sel;
  logic [DW-1:0]        spi_data;
  logic                 spi_rd;
  logic                 spi_busy;
  logic                 spi_done;
  logic [DW-1:0]        spi_rdata;
  logic [1:0]           grant_id;
  logic                 busy;
  logic [15:0]          timeout_cnt;

  int n_checks = 0;
  int n_errors = 0;

  zest_spi_arb #(
    .N_REQ   (N_REQ),
    .DW      (DW),
    .CSW     (CSW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .lb_clk      (lb_clk),
    .reset       (reset),
    .req         (req),
    .req_sel     (req_sel),
    .req_data    (req_data),
    .req_rd      (req_rd),
    .ack         (ack),
    .err         (err),
    .rdata       (rdata),
    .spi_start   (spi_start),
    .spi_sel     (spi_sel),
    .spi_data    (spi_data),
    .spi_rd      (spi_rd),
    .spi_busy    (spi_busy),
    .spi_done    (spi_done),
    .spi_rdata   (spi_rdata),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_cnt (timeout_cnt)
  );

  always #5 lb_clk = ~lb_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge lb_clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (spi_start !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(spi_start), 32'd1);
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (ack === '0 && n < 60) begin
      step();
      n++;
    end
    chk(tag, 32'(ack !== '0), 32'd1);
  endtask

  task automatic pulse_done(input logic [DW-1:0] rd_val);
    spi_done  = 1'b1;
    spi_rdata = rd_val;
    step();
    spi_done  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_start;
    int n_ack;
    logic [1:0] exp_id;

    reset = 1'b1; req = '0; req_sel = '0; req_data = '0; req_rd = '0;
    spi_busy = 1'b0; spi_done = 1'b0; spi_rdata = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel", 32'(spi_sel), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_tcnt", 32'(timeout_cnt), 32'd0);

    // Single transaction on requester 1.
    req_sel[3 +: 3] = 3'd2; req_data[24 +: 24] = 24'h123456; req_rd[1] = 1'b1;
    req = 3'b010;
    step();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_grant", 32'(grant_id), 32'd1);
    chk("t1_nostart", 32'(spi_start), 32'd0);
    step();
    chk("t1_start", 32'(spi_start), 32'd1);
    chk("t1_sel", 32'(spi_sel), 32'd2);
    chk("t1_data", 32'(spi_data), 32'h123456);
    chk("t1_rd", 32'(spi_rd), 32'd1);
    step();
    chk("t1_start_pulse", 32'(spi_start), 32'd0);
    chk("t1_data_clr", 32'(spi_data), 32'd0);
    chk("t1_sel_hold", 32'(spi_sel), 32'd2);
    repeat (8) step();
    pulse_done(24'hABCDEF);
    chk("t1_ack_early", 32'(ack), 32'd0);
    step();
    chk("t1_ack", 32'(ack), 32'b010);
    chk("t1_rdata", 32'(rdata), 32'hABCDEF);
    chk("t1_err", 32'(err), 32'd0);
    req = '0;
    step();
    chk("t1_ack_once", 32'(ack), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Busy hold-off on requester 2.
    req_sel[6 +: 3] = 3'd5; req_data[48 +: 24] = 24'h00AA55; req_rd[2] = 1'b0;
    spi_busy = 1'b1;
    req = 3'b100;
    step();
    n_start = 0;
    repeat (5) begin
      step();
      if (spi_start) n_start++;
    end
    spi_busy = 1'b0;
    step();
    chk("bh_first_free", 32'(spi_start), 32'd1);
    chk("bh_data", 32'(spi_data), 32'h00AA55);
    chk("bh_sel", 32'(spi_sel), 32'd5);
    if (spi_start) n_start++;
    repeat (2) begin
      step();
      if (spi_start) n_start++;
    end
    chk("bh_one_start", 32'(n_start), 32'd1);
    pulse_done(24'h55AA00);
    wait_ack("bh_ack_seen");
    chk("bh_ack", 32'(ack), 32'b100);
    chk("bh_rdata", 32'(rdata), 32'h55AA00);
    req = '0;
    step();

    // Timeout on requester 0 with no spi_done.
    req_sel[0 +: 3] = 3'd1; req_data[0 +: 24] = 24'h0F0F0F; req_rd[0] = 1'b0;
    req = 3'b001;
    wait_start("to_start");
    n_ack = 0;
    repeat (15) begin
      step();
      if (ack !== '0) n_ack++;
    end
    chk("to_no_early_ack", 32'(n_ack), 32'd0);
    step();
    chk("to_ack", 32'(ack), 32'b001);
    chk("to_err", 32'(err), 32'b001);
    chk("to_rdata", 32'(rdata), 32'd0);
    chk("to_tcnt", 32'(timeout_cnt), 32'd1);
    req = '0;
    step();
    chk("to_err_clr", 32'(err), 32'd0);

    // spi_done coincident with the timeout cycle: done wins.
    req = 3'b001;
    wait_start("tod_start");
    repeat (14) step();
    pulse_done(24'h00C0DE);
    step();
    chk("tod_ack", 32'(ack), 32'b001);
    chk("tod_err", 32'(err), 32'd0);
    chk("tod_rdata", 32'(rdata), 32'h00C0DE);
    chk("tod_tcnt", 32'(timeout_cnt), 32'd1);
    req = '0;
    step();

    // Reset while in WAIT; a late spi_done must be ignored.
    req_sel[3 +: 3] = 3'd3; req_data[24 +: 24] = 24'h777777; req_rd[1] = 1'b1;
    req = 3'b010;
    wait_start("rw_start");
    repeat (2) step();
    chk("rw_in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    req = '0;
    step();
    reset = 1'b0;
    chk("rw_outs", 32'({ack, err, spi_start, spi_rd, busy, grant_id}), 32'd0);
    chk("rw_sel", 32'(spi_sel), 32'd0);
    chk("rw_rdata", 32'(rdata), 32'd0);
    chk("rw_tcnt", 32'(timeout_cnt), 32'd0);
    step();
    pulse_done(24'h123123);
    n_ack = 0;
    repeat (4) begin
      step();
      if (ack !== '0 || busy !== 1'b0) n_ack++;
    end
    chk("rw_late_done", 32'(n_ack), 32'd0);

    // Spurious spi_done in IDLE with no request.
    pulse_done(24'hBADBAD);
    chk("sp_ack", 32'(ack), 32'd0);
    chk("sp_busy", 32'(busy), 32'd0);
    chk("sp_start", 32'(spi_start), 32'd0);
    step();
    chk("sp_rdata", 32'(rdata), 32'd0);

    // Contention: all requests held; pointer restarts at 0 after reset.
    for (int i = 0; i < 3; i++) begin
      req_sel[i*3 +: 3]   = 3'(i + 1);
      req_data[i*24 +: 24] = 24'(32'h100000 * (i + 1) + 32'h11);
      req_rd[i]           = 1'b0;
    end
    req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      exp_id = 2'(t % 3);
      wait_start("rr_start");
      chk("rr_grant", 32'(grant_id), 32'(exp_id));
      chk("rr_sel", 32'(spi_sel), 32'(exp_id) + 32'd1);
      chk("rr_data", 32'(spi_data), 32'h100000 * (32'(exp_id) + 1) + 32'h11);
      repeat (3) step();
      pulse_done(24'(32'hA00000 + 32'(t)));
      wait_ack("rr_ack_seen");
      chk("rr_ack", 32'(ack), 32'd1 << exp_id);
      chk("rr_rdata", 32'(rdata), 32'hA00000 + 32'(t));
    end
    req = '0;
    step();
    chk("rr_tcnt", 32'(timeout_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zest_spi_arb.md
Name: zest_spi_arb

Overview:
- Round-robin arbiter and sequencer that shares one Zest configuration SPI master (U15/U18/ADC/DAC chain) between N requesters.
- Typical requesters are the local-bus host path, the periodic U15/U18 monitor poller and the startup init sequencer.
- Sits in the lb_clk domain between the requesters and the SPI engine inside the Zest wrapper.
- Serialises whole transactions: grant, start, wait for done or timeout, then return read data and ack to the winner.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- DW, 24, SPI transaction payload/readback width.
- CSW, 3, chip-select index width.
- TIMEOUT, 4095, maximum WAIT cycles before abort (≥2).
- IDW, $clog2(N_REQ) (localparam), grant index width.

Ports:
- lb_clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level.
- req_sel  in  N_REQ*CSW  per-requester chip-select index; slice i belongs to requester i.
- req_data  in  N_REQ*DW  per-requester write payload.
- req_rd  in  N_REQ  per-requester read flag.
- ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- err  out  N_REQ  timeout flag; valid only with ack.
- rdata  out  DW  readback, shared by all requesters; valid only with ack.
- spi_start  out  1  one-cycle start pulse to the SPI master.
- spi_sel  out  CSW  chip select for the transaction.
- spi_data  out  DW  payload for the transaction.
- spi_rd  out  1  read flag for the transaction.
- spi_busy  in  1  SPI master busy.
- spi_done  in  1  SPI master completion pulse.
- spi_rdata  in  DW  SPI readback, valid with spi_done.
- grant_id  out  IDW  index of the current or last grant.
- busy  out  1  high in any state other than IDLE.
- timeout_cnt  out  16  saturating count of timeouts.

Behaviour:
- All outputs are registered. After reset every output is 0, state is IDLE, the RR pointer is 0 and the wait counter is 0.
- Requester contract:
  - Hold req and its payload stable from assertion until ack.
  - Drop req on the edge where ack is sampled.
  - Dropping req early does not abort a granted transaction; it still runs and acks.
- FSM states are IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - When any req bit is set, pick the first set bit at or after the RR pointer, wrapping modulo N_REQ.
  - Latch grant_id and that requester's sel/data/rd.
  - Move to ISSUE.
- ISSUE:
  - If spi_busy=0, pulse spi_start for one cycle with spi_sel/spi_data/spi_rd driven, clear the wait counter and move to WAIT.
  - Otherwise stay in ISSUE; there is no timeout here.
- WAIT:
  - Increment the wait counter every cycle.
  - On spi_done: capture spi_rdata into rdata, clear the error and move to ACK.
  - Otherwise, when the counter reaches TIMEOUT: set err for the grant, set rdata to 0, increment timeout_cnt (saturating at 0xFFFF) and move to ACK.
  - If spi_done and the timeout occur in the same cycle, done wins: no err, and timeout_cnt is unchanged.
- ACK:
  - ack[grant_id]=1 for exactly one cycle, with err[grant_id] as determined in WAIT.
  - RR pointer becomes (grant_id+1) mod N_REQ.
  - Return to IDLE.
- Latency: req seen in IDLE at cycle 0; spi_start at cycle 1 when not busy; ack one cycle after the state enters ACK from the spi_done cycle. Back-to-back grants leave one IDLE cycle between ack and the next spi_start.
- spi_done arriving in IDLE, ISSUE or ACK is ignored.
- spi_start and spi_data are held only during the start cycle. spi_sel and spi_rd stay stable from ISSUE through ACK.
- Reset mid-transaction: all outputs return to 0 on the next edge. The SPI master is not aborted; its later spi_done arrives in IDLE and is ignored.
- Fairness: with all requests continuously asserted, grants cycle 0,1,…,N_REQ-1.

Decomposition:
- Package zest_spi_arb_pkg holds:
  - state_t enum {IDLE, ISSUE, WAIT, ACK};
  - localparam widths (timeout counter 16 bits);
  - an rr_next function.
- One sub-module, rr_pick: combinational round-robin picker. Inputs are req and the pointer; outputs are a valid flag and the index.

Test Plan:
- Single transaction: req[1] with sel=2, data=0x123456, rd=1; spi_done 10 cycles after start with spi_rdata=0xABCDEF.
  - Expect spi_start at cycle 1 with spi_sel=2 and spi_data=0x123456.
  - Expect ack[1] one cycle after done, with rdata=0xABCDEF and err=0.
- Contention: all three req held, and each requester re-asserts immediately after its ack. Expect grant order 0,1,2,0,1,2 with one ack per transaction.
- Busy hold-off: spi_busy high for 5 cycles on entry to ISSUE. Expect spi_start exactly one cycle, on the first cycle with busy=0.
- Timeout: TIMEOUT=15, no spi_done.
  - Expect ack[0] with err[0]=1 and rdata=0 after 15 WAIT cycles, and timeout_cnt=1.
  - Rerun with spi_done on the timeout cycle: expect err=0 and timeout_cnt unchanged.
- Reset in WAIT: assert reset for 1 cycle.
  - Expect all outputs 0 on the next cycle and the pointer at 0.
  - A later spi_done produces no ack.
- Spurious spi_done in IDLE, with no req: expect no ack, no state change and busy=0.
